// File: rtl/move_sequencer.sv
// Move sequencer for the 24 game: keypad events -> operand/operator/operand selection, one combine request per move.
// All outputs registered; op_req holds with op_a/op_b/op_code stable until op_ack, so the datapath sets the pace.
module move_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int TO_W           = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       key_press,
  input  logic [3:0] key_code,
  input  logic [3:0] valid,
  input  logic       op_ack,
  output logic [2:0] s1,
  output logic [2:0] s2,
  output logic       op_req,
  output logic [1:0] op_a,
  output logic [1:0] op_b,
  output logic [1:0] op_code,
  output logic [1:0] move_cnt,
  output logic       moves_done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK_A  = 3'd1,
    PICK_OP = 3'd2,
    PICK_B  = 3'd3,
    ISSUE   = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      s1_q, s1_d;
  logic [2:0]      s2_q, s2_d;
  logic            op_req_q, op_req_d;
  logic [1:0]      op_a_q, op_a_d;
  logic [1:0]      op_b_q, op_b_d;
  logic [1:0]      op_code_q, op_code_d;
  logic [1:0]      move_cnt_q, move_cnt_d;
  logic            moves_done_q, moves_done_d;
  logic            timeout_q, timeout_d;
  logic [TO_W-1:0] to_q, to_d;

  logic       key_digit, key_op, key_cancel, expired;
  logic [1:0] dig_idx, key_opv;
  logic [2:0] key_slot;

  always_comb begin
    dig_idx    = key_code[1:0] - 2'd1;
    key_slot   = key_code[2:0];
    // A..D have low bits 2,3,0,1; subtracting 2 maps them onto op codes 0..3
    key_opv    = key_code[1:0] - 2'd2;
    key_digit  = key_press && (key_code >= 4'd1) && (key_code <= 4'd4) && valid[dig_idx];
    key_op     = key_press && (key_code >= 4'hA) && (key_code <= 4'hD);
    key_cancel = key_press && (key_code == 4'hE);
    expired    = (to_q == TO_LAST);
  end

  always_comb begin
    state_d      = state_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    op_req_d     = op_req_q;
    op_code_d    = op_code_q;
    move_cnt_d   = move_cnt_q;
    moves_done_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (game_active) begin
          state_d    = PICK_A;
          move_cnt_d = 2'd0;
        end
      end
      PICK_A: begin
        if (!game_active) begin
          state_d   = IDLE;
          s1_d      = 3'd0;
          s2_d      = 3'd0;
          op_code_d = 2'd0;
        end else if (key_digit) begin
          s1_d    = key_slot;
          state_d = PICK_OP;
        end
      end
      PICK_OP: begin
        if (!game_active) begin
          state_d   = IDLE;
          s1_d      = 3'd0;
          s2_d      = 3'd0;
          op_code_d = 2'd0;
        end else if (key_op) begin
          op_code_d = key_opv;
          state_d   = PICK_B;
        end else if (key_digit) begin
          s1_d = key_slot;
        end else if (key_cancel) begin
          s1_d    = 3'd0;
          state_d = PICK_A;
        end else if (!key_press && expired) begin
          s1_d      = 3'd0;
          s2_d      = 3'd0;
          op_code_d = 2'd0;
          timeout_d = 1'b1;
          state_d   = PICK_A;
        end
      end
      PICK_B: begin
        if (!game_active) begin
          state_d   = IDLE;
          s1_d      = 3'd0;
          s2_d      = 3'd0;
          op_code_d = 2'd0;
        end else if (key_digit && (key_slot != s1_q)) begin
          s2_d     = key_slot;
          op_req_d = 1'b1;
          state_d  = ISSUE;
        end else if (key_op) begin
          op_code_d = key_opv;
        end else if (key_cancel) begin
          op_code_d = 2'd0;
          state_d   = PICK_OP;
        end else if (!key_press && expired) begin
          s1_d      = 3'd0;
          s2_d      = 3'd0;
          op_code_d = 2'd0;
          timeout_d = 1'b1;
          state_d   = PICK_A;
        end
      end
      ISSUE: begin
        // game_active dropping here is deferred until the datapath acknowledges
        if (op_ack) begin
          op_req_d  = 1'b0;
          s1_d      = 3'd0;
          s2_d      = 3'd0;
          op_code_d = 2'd0;
          if (move_cnt_q != 2'd3) begin
            move_cnt_d = move_cnt_q + 2'd1;
          end
          if (move_cnt_d == 2'd3) begin
            moves_done_d = 1'b1;
            state_d      = IDLE;
          end else if (!game_active) begin
            state_d = IDLE;
          end else begin
            state_d = PICK_A;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        s1_d     = 3'd0;
        s2_d     = 3'd0;
        op_req_d = 1'b0;
      end
    endcase

    op_a_d = (s1_d == 3'd0) ? 2'd0 : (s1_d[1:0] - 2'd1);
    op_b_d = (s2_d == 3'd0) ? 2'd0 : (s2_d[1:0] - 2'd1);

    if (key_press || (state_d != state_q) || !((state_q == PICK_OP) || (state_q == PICK_B))) begin
      to_d = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_q         <= 3'd0;
      s2_q         <= 3'd0;
      op_req_q     <= 1'b0;
      op_a_q       <= 2'd0;
      op_b_q       <= 2'd0;
      op_code_q    <= 2'd0;
      move_cnt_q   <= 2'd0;
      moves_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      op_req_q     <= op_req_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      move_cnt_q   <= move_cnt_d;
      moves_done_q <= moves_done_d;
      timeout_q    <= timeout_d;
      to_q         <= to_d;
    end
  end

  assign s1         = s1_q;
  assign s2         = s2_q;
  assign op_req     = op_req_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_code    = op_code_q;
  assign move_cnt   = move_cnt_q;
  assign moves_done = moves_done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: vector table for the move flow, hand sequences for timeout and reset during ISSUE.
module tb_move_sequencer;

  logic       clk;
  logic       rst;
  logic       game_active;
  logic       key_press;
  logic [3:0] key_code;
  logic [3:0] valid;
  logic       op_ack;
  logic [2:0] s1, s2;
  logic       op_req;
  logic [1:0] op_a, op_b, op_code, move_cnt;
  logic       moves_done, timeout;

  int n_chk;
  int n_fail;

  move_sequencer #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .game_active(game_active), .key_press(key_press),
    .key_code(key_code), .valid(valid), .op_ack(op_ack),
    .s1(s1), .s2(s2), .op_req(op_req), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .move_cnt(move_cnt), .moves_done(moves_done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ga;
    logic        kp;
    logic [3:0]  kc;
    logic [3:0]  vld;
    logic        ack;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed as {s1,s2,op_req,op_a,op_b,op_code,move_cnt,moves_done,timeout}
  function automatic logic [16:0] mk(input int e_s1, e_s2, e_rq, e_a, e_b, e_c, e_n, e_d, e_t);
    return {3'(e_s1), 3'(e_s2), 1'(e_rq), 2'(e_a), 2'(e_b), 2'(e_c), 2'(e_n), 1'(e_d), 1'(e_t)};
  endfunction

  function automatic void add(input int ga, kp, kc, vld, ack,
                              input int e_s1, e_s2, e_rq, e_a, e_b, e_c, e_n, e_d, e_t);
    vec_t v;
    v.ga  = 1'(ga);
    v.kp  = 1'(kp);
    v.kc  = 4'(kc);
    v.vld = 4'(vld);
    v.ack = 1'(ack);
    v.exp = mk(e_s1, e_s2, e_rq, e_a, e_b, e_c, e_n, e_d, e_t);
    vecs.push_back(v);
  endfunction

  function automatic logic [16:0] outs();
    return {s1, s2, op_req, op_a, op_b, op_code, move_cnt, moves_done, timeout};
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got s1/s2/req/a/b/op/cnt/done/to=%h required %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge and outputs are sampled there too.
  task automatic step(input logic ga, kp, input logic [3:0] kc, vld, input logic ack);
    game_active = ga;
    key_press   = kp;
    key_code    = kc;
    valid       = vld;
    op_ack      = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    game_active = 1'b0;
    key_press   = 1'b0;
    key_code    = 4'h0;
    valid       = 4'hF;
    op_ack      = 1'b0;

    //    ga kp kc   vld  ack | s1 s2 rq a b op cnt dn to
    add(1, 0, 4'h0, 4'hF, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h2, 4'hF, 0,   2, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 4'hA, 4'hF, 0,   2, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 4'h4, 4'hF, 0,   2, 4, 1, 1, 3, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'hF, 0,   2, 4, 1, 1, 3, 0, 0, 0, 0);
    add(1, 1, 4'h1, 4'hF, 0,   2, 4, 1, 1, 3, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'hF, 1,   0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 4'h3, 4'hB, 1,   0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 4'h1, 4'hB, 0,   1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 4'hB, 4'hB, 0,   1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 4'h1, 4'hB, 0,   1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 4'h2, 4'hB, 0,   1, 2, 1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 4'h0, 4'hB, 1,   0, 0, 0, 0, 0, 0, 2, 0, 0);
    add(1, 1, 4'h1, 4'hB, 0,   1, 0, 0, 0, 0, 0, 2, 0, 0);
    add(1, 1, 4'hC, 4'hB, 0,   1, 0, 0, 0, 0, 2, 2, 0, 0);
    add(1, 1, 4'hE, 4'hB, 0,   1, 0, 0, 0, 0, 0, 2, 0, 0);
    add(1, 1, 4'hE, 4'hB, 0,   0, 0, 0, 0, 0, 0, 2, 0, 0);
    add(1, 1, 4'hA, 4'hB, 0,   0, 0, 0, 0, 0, 0, 2, 0, 0);
    add(1, 1, 4'h4, 4'hB, 0,   4, 0, 0, 3, 0, 0, 2, 0, 0);
    add(1, 1, 4'hD, 4'hB, 0,   4, 0, 0, 3, 0, 3, 2, 0, 0);
    add(1, 1, 4'h1, 4'hB, 0,   4, 1, 1, 3, 0, 3, 2, 0, 0);
    add(0, 0, 4'h0, 4'hB, 0,   4, 1, 1, 3, 0, 3, 2, 0, 0);
    add(0, 0, 4'h0, 4'hB, 1,   0, 0, 0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 4'h0, 4'hB, 0,   0, 0, 0, 0, 0, 0, 3, 0, 0);
    add(0, 1, 4'h1, 4'hB, 0,   0, 0, 0, 0, 0, 0, 3, 0, 0);
    add(1, 0, 4'h0, 4'hB, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h2, 4'hB, 0,   2, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'hB, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'h2, 4'hB, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    chk("reset", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ga, vecs[i].kp, vecs[i].kc, vecs[i].vld, vecs[i].ack);
      chk($sformatf("row%0d", i), outs(), vecs[i].exp);
    end

    // Timeout: 16 idle cycles in PICK_OP abandon the selection
    do_reset();
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'h1, 4'hF, 1'b0);
    chk("to_pick", outs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
      chk($sformatf("to_wait%0d", i), outs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    chk("to_fire", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    chk("to_pulse_end", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 4'h2, 4'hF, 1'b0);
    chk("to_repick", outs(), mk(2, 0, 0, 1, 0, 0, 0, 0, 0));

    // A key landing on the expiry cycle wins, and restarts the count
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    end
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0);
    chk("to_key_wins", outs(), mk(2, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
      chk($sformatf("to_rewait%0d", i), outs(), mk(2, 0, 0, 1, 0, 0, 0, 0, 0));
    end
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    chk("to_refire", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset while a request is outstanding
    step(1'b1, 1'b1, 4'h1, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'hC, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'h3, 4'hF, 1'b0);
    chk("rst_issue_req", outs(), mk(1, 3, 1, 0, 2, 2, 0, 0, 0));
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    chk("rst_issue_clear", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step(1'b1, 1'b0, 4'h0, 4'hF, 1'b1);
    chk("rst_issue_after", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
